// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV64I+Zba core.
// Optional performance counters are compiled in with `define CORE_CTRL_PERF_EN.
module core_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 0,
    parameter int unsigned TMO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_valid,
    output logic        ir_we,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    output logic [3:0]  alu_op,
    output logic        alu_w,
    output logic        alu_src_imm,
    output logic        imm_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        pc_we,
    output logic        retire,
    output logic        illegal
`ifdef CORE_CTRL_PERF_EN
    ,
    output logic [63:0] perf_cycles,
    output logic [63:0] perf_instret
`endif
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE} cls_t;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_SH1ADD, ALU_SH2ADD, ALU_SH3ADD, ALU_ADD_UW, ALU_SLLI_UW
    } alu_op_t;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DMEM_TIMEOUT == 0 ? 0 : DMEM_TIMEOUT - 1);

    state_t          state;
    cls_t            cls;
    logic [TMO_W-1:0] tmo_cnt;

    logic    dec_legal, dec_w, dec_imm, dec_ssel;
    alu_op_t dec_op;
    cls_t    dec_cls;

    function automatic alu_op_t base_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_t sh_op(input logic [2:0] f3);
        case (f3[2:1])
            2'b01:   return ALU_SH1ADD;
            2'b10:   return ALU_SH2ADD;
            default: return ALU_SH3ADD;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        dec_legal = 1'b0;
        dec_op    = ALU_ADD;
        dec_w     = 1'b0;
        dec_imm   = 1'b0;
        dec_ssel  = 1'b0;
        dec_cls   = C_ALU;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_op    = base_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && funct3 inside {3'b000, 3'b101}) begin
                    dec_legal = 1'b1;
                    dec_op    = base_op(funct3, 1'b1);
                end else if (funct7 == 7'b0010000 && funct3 inside {3'b010, 3'b100, 3'b110}) begin
                    dec_legal = 1'b1;
                    dec_op    = sh_op(funct3);
                end
            end
            OPC_OP_32: begin
                if (funct7 == 7'b0000000 && funct3 inside {3'b000, 3'b001, 3'b101}) begin
                    dec_legal = 1'b1;
                    dec_w     = 1'b1;
                    dec_op    = base_op(funct3, 1'b0);
                end else if (funct7 == 7'b0100000 && funct3 inside {3'b000, 3'b101}) begin
                    dec_legal = 1'b1;
                    dec_w     = 1'b1;
                    dec_op    = base_op(funct3, 1'b1);
                end else if (funct7 == 7'b0000100 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_ADD_UW;
                end else if (funct7 == 7'b0010000 && funct3 inside {3'b010, 3'b100, 3'b110}) begin
                    // shNadd.uw shares the shNadd codes; the datapath zero-extends rs1 on OP-32.
                    dec_legal = 1'b1;
                    dec_op    = sh_op(funct3);
                end
            end
            OPC_OP_IMM: begin
                dec_imm   = 1'b1;
                dec_legal = !(funct3 inside {3'b001, 3'b101}) ||
                            funct7[6:1] inside {6'b000000, 6'b010000};
                dec_op    = base_op(funct3, funct3 == 3'b101 && funct7[5]);
            end
            OPC_OP_IMM_32: begin
                dec_imm = 1'b1;
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_w     = 1'b1;
                end else if (funct3 == 3'b001 && funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                    dec_w     = 1'b1;
                    dec_op    = ALU_SLL;
                end else if (funct3 == 3'b001 && funct7[6:1] == 6'b000010) begin
                    dec_legal = 1'b1;
                    dec_op    = ALU_SLLI_UW;
                end else if (funct3 == 3'b101 && funct7 inside {7'b0000000, 7'b0100000}) begin
                    dec_legal = 1'b1;
                    dec_w     = 1'b1;
                    dec_op    = base_op(funct3, funct7[5]);
                end
            end
            OPC_LOAD: begin
                dec_legal = funct3 != 3'b111;
                dec_imm   = 1'b1;
                dec_cls   = C_LOAD;
            end
            OPC_STORE: begin
                dec_legal = !funct3[2];
                dec_imm   = 1'b1;
                dec_ssel  = 1'b1;
                dec_cls   = C_STORE;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments and clears asynchronously on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            cls         <= C_ALU;
            tmo_cnt     <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            illegal     <= 1'b0;
            alu_op      <= 4'd0;
            alu_w       <= 1'b0;
            alu_src_imm <= 1'b0;
            imm_sel     <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_valid) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_op      <= dec_op;
                    alu_w       <= dec_w;
                    alu_src_imm <= dec_imm;
                    imm_sel     <= dec_ssel;
                    cls         <= dec_cls;
                    if (dec_legal) begin
                        state <= S_EXEC;
                    end else begin
                        state   <= S_TRAP;
                        illegal <= 1'b1;
                    end
                end
                S_EXEC: begin
                    tmo_cnt <= '0;
                    if (cls == C_ALU) begin
                        state <= S_WB;
                    end else begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == C_STORE);
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (cls == C_STORE) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end else begin
                            state <= S_WB;
                        end
                    end else if (DMEM_TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                        state    <= S_TRAP;
                        illegal  <= 1'b1;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_TRAP:  ;
                default: state <= S_TRAP;
            endcase
        end
    end

    // Input-qualified strobes must act in the same cycle as imem_valid / dmem_ready.
    assign ir_we  = (state == S_FETCH) && imem_req && imem_valid;
    assign retire = (state == S_WB) || ((state == S_MEM) && dmem_ready && cls == C_STORE);
    assign pc_we  = retire;
    assign rf_we  = (state == S_WB) && (rd != 5'd0);
    assign wb_sel = (state == S_WB) && (cls == C_LOAD);

`ifdef CORE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cycles  <= 64'd0;
            perf_instret <= 64'd0;
        end else begin
            if (state != S_TRAP) perf_cycles <= perf_cycles + 64'd1;
            if (retire)          perf_instret <= perf_instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Directed self-checking bench for core_ctrl; the bench plays the decoder and both memories.
// Cycle 1 is the first cycle with imem_req=1 after reset release.
module tb_core_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_valid = 1'b0;
    logic       dmem_ready = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic [4:0] rd = 5'd0;
    logic       imem_req, ir_we, alu_w, alu_src_imm, imm_sel, dmem_req, dmem_we;
    logic       rf_we, wb_sel, pc_we, retire, illegal;
    logic [3:0] alu_op;
`ifdef CORE_CTRL_PERF_EN
    logic [63:0] perf_cycles, perf_instret;
`endif

    int checks = 0;
    int errors = 0;

    int r_retire_cyc, r_ir_we_cyc, r_illegal_cyc, r_req_cycles, r_fetch_req, r_retires;
    logic [3:0] r_alu_op;
    logic r_alu_w, r_src_imm, r_imm_sel, r_rf_we, r_wb_sel, r_pc_we, r_dmem_we_seen, r_rf_we_seen;

    localparam logic [31:0] I_ADD_UW = 32'h080302BB;
    localparam logic [31:0] I_SH3ADD = 32'h2030E0B3;
    localparam logic [31:0] I_LD     = 32'h00813383;
    localparam logic [31:0] I_SD     = 32'h00713423;
    localparam logic [31:0] I_BAD    = 32'h0000007F;

    always #5 clk = ~clk;

    core_ctrl #(.DMEM_TIMEOUT(4), .TMO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_valid(imem_valid), .ir_we(ir_we),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
        .alu_op(alu_op), .alu_w(alu_w), .alu_src_imm(alu_src_imm), .imm_sel(imm_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .retire(retire), .illegal(illegal)
`ifdef CORE_CTRL_PERF_EN
        , .perf_cycles(perf_cycles), .perf_instret(perf_instret)
`endif
    );

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] r, input logic [6:0] opc);
        return {f7, 10'd0, f3, r, opc};
    endfunction

    task automatic set_instr(input logic [31:0] w);
        opcode = w[6:0];
        rd     = w[11:7];
        funct3 = w[14:12];
        funct7 = w[31:25];
    endtask

    // Leaves the bench 2 time units after the first edge following release (cycle 1).
    task automatic do_reset();
        rst_n = 1'b0;
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction for at most max_cyc cycles, recording what the DUT did.
    task automatic run_op(input logic [31:0] w, input int vdelay, input int rdelay, input int max_cyc);
        int req_cnt;
        logic done;
        set_instr(w);
        req_cnt = 0;
        r_retire_cyc = -1; r_ir_we_cyc = -1; r_illegal_cyc = -1;
        r_fetch_req = 0; r_retires = 0;
        r_dmem_we_seen = 1'b0; r_rf_we_seen = 1'b0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            imem_valid = (cyc == vdelay + 1);
            dmem_ready = 1'b0;
            if (dmem_req) begin
                dmem_ready = (rdelay >= 0) && (req_cnt == rdelay);
                if (dmem_we) r_dmem_we_seen = 1'b1;
                req_cnt++;
            end
            #1;
            if (imem_req && r_ir_we_cyc < 0) r_fetch_req++;
            if (ir_we && r_ir_we_cyc < 0) r_ir_we_cyc = cyc;
            if (rf_we) r_rf_we_seen = 1'b1;
            if (illegal && r_illegal_cyc < 0) r_illegal_cyc = cyc;
            done = retire;
            if (retire) begin
                r_retires++;
                r_retire_cyc = cyc;
                r_alu_op = alu_op; r_alu_w = alu_w; r_src_imm = alu_src_imm; r_imm_sel = imm_sel;
                r_rf_we = rf_we; r_wb_sel = wb_sel; r_pc_we = pc_we;
            end
            @(posedge clk);
            #2;
            imem_valid = 1'b0;
            dmem_ready = 1'b0;
            if (done) break;
        end
        r_req_cycles = req_cnt;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_valid = 1'b1;
        dmem_ready = 1'b1;
        set_instr(I_SD);
        @(posedge clk);
        #3;
        checks++;
        if ({imem_req, ir_we, alu_op, alu_w, alu_src_imm, imm_sel, dmem_req, dmem_we,
             rf_we, wb_sel, pc_we, retire, illegal} !== 16'd0) begin
            errors++;
            $display("FAIL reset_outputs: imem_req=%b ir_we=%b dmem_req=%b retire=%b illegal=%b, required all 0",
                     imem_req, ir_we, dmem_req, retire, illegal);
        end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_release_req: got %b required 0", imem_req); end
        @(posedge clk);
        #2;
        checks++;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL first_clock_req: got %b required 1", imem_req); end
    endtask

    task automatic test_alu_add_uw();
        do_reset();
        run_op(I_ADD_UW, 0, 0, 10);
        checks++; if (r_ir_we_cyc !== 1)   begin errors++; $display("FAIL add_uw_ir_we_cycle: got %0d required 1", r_ir_we_cyc); end
        checks++; if (r_retire_cyc !== 4)  begin errors++; $display("FAIL add_uw_retire_cycle: got %0d required 4", r_retire_cyc); end
        checks++; if (r_alu_op !== 4'd13)  begin errors++; $display("FAIL add_uw_alu_op: got %0d required 13", r_alu_op); end
        checks++; if (r_alu_w !== 1'b0)    begin errors++; $display("FAIL add_uw_alu_w: got %b required 0", r_alu_w); end
        checks++; if (r_src_imm !== 1'b0)  begin errors++; $display("FAIL add_uw_src_imm: got %b required 0", r_src_imm); end
        checks++; if ({r_rf_we, r_pc_we, r_wb_sel} !== 3'b110)
            begin errors++; $display("FAIL add_uw_wb: rf_we/pc_we/wb_sel got %b%b%b required 110", r_rf_we, r_pc_we, r_wb_sel); end
        checks++; if (imem_req !== 1'b1)   begin errors++; $display("FAIL add_uw_refetch: got %b required 1", imem_req); end
`ifdef CORE_CTRL_PERF_EN
        checks++; if (perf_cycles !== 64'd5)  begin errors++; $display("FAIL perf_cycles: got %0d required 5", perf_cycles); end
        checks++; if (perf_instret !== 64'd1) begin errors++; $display("FAIL perf_instret: got %0d required 1", perf_instret); end
`endif
    endtask

    task automatic test_fetch_stall();
        run_op(I_SH3ADD, 3, 0, 12);
        checks++; if (r_fetch_req !== 4)   begin errors++; $display("FAIL stall_imem_req_cycles: got %0d required 4", r_fetch_req); end
        checks++; if (r_ir_we_cyc !== 4)   begin errors++; $display("FAIL stall_ir_we_cycle: got %0d required 4", r_ir_we_cyc); end
        checks++; if (r_retire_cyc !== 7)  begin errors++; $display("FAIL stall_retire_cycle: got %0d required 7", r_retire_cyc); end
        checks++; if (r_alu_op !== 4'd12)  begin errors++; $display("FAIL sh3add_alu_op: got %0d required 12", r_alu_op); end
        checks++; if (r_rf_we !== 1'b1)    begin errors++; $display("FAIL sh3add_rf_we: got %b required 1", r_rf_we); end
    endtask

    task automatic test_load();
        run_op(I_LD, 0, 2, 12);
        checks++; if (r_req_cycles !== 3)  begin errors++; $display("FAIL ld_dmem_req_cycles: got %0d required 3", r_req_cycles); end
        checks++; if (r_dmem_we_seen !== 1'b0) begin errors++; $display("FAIL ld_dmem_we: got %b required 0", r_dmem_we_seen); end
        checks++; if (r_retire_cyc !== 7)  begin errors++; $display("FAIL ld_retire_cycle: got %0d required 7", r_retire_cyc); end
        checks++; if ({r_wb_sel, r_rf_we} !== 2'b11)
            begin errors++; $display("FAIL ld_wb: wb_sel/rf_we got %b%b required 11", r_wb_sel, r_rf_we); end
        checks++; if ({r_alu_op, r_src_imm, r_imm_sel} !== 6'b0000_1_0)
            begin errors++; $display("FAIL ld_alu: op=%0d src_imm=%b imm_sel=%b required 0/1/0", r_alu_op, r_src_imm, r_imm_sel); end
    endtask

    task automatic test_store();
        run_op(I_SD, 0, 0, 10);
        checks++; if (r_retire_cyc !== 4)  begin errors++; $display("FAIL sd_retire_cycle: got %0d required 4", r_retire_cyc); end
        checks++; if (r_req_cycles !== 1)  begin errors++; $display("FAIL sd_dmem_req_cycles: got %0d required 1", r_req_cycles); end
        checks++; if (r_dmem_we_seen !== 1'b1) begin errors++; $display("FAIL sd_dmem_we: got %b required 1", r_dmem_we_seen); end
        checks++; if ({r_imm_sel, r_src_imm, r_pc_we} !== 3'b111)
            begin errors++; $display("FAIL sd_ctrl: imm_sel/src_imm/pc_we got %b%b%b required 111", r_imm_sel, r_src_imm, r_pc_we); end
        checks++; if (r_rf_we_seen !== 1'b0) begin errors++; $display("FAIL sd_rf_we: got %b required 0", r_rf_we_seen); end
        checks++; if (r_retires !== 1)     begin errors++; $display("FAIL sd_retire_count: got %0d required 1", r_retires); end
    endtask

    task automatic test_decode_misc();
        // addiw x1: word op with immediate
        run_op(mk(7'b0000000, 3'b000, 5'd1, 7'b0011011), 0, 0, 10);
        checks++; if ({r_alu_op, r_alu_w, r_src_imm} !== 6'b0000_1_1)
            begin errors++; $display("FAIL addiw_decode: op=%0d w=%b imm=%b required 0/1/1", r_alu_op, r_alu_w, r_src_imm); end
        // sraiw x2
        run_op(mk(7'b0100000, 3'b101, 5'd2, 7'b0011011), 0, 0, 10);
        checks++; if ({r_alu_op, r_alu_w} !== 5'b0111_1)
            begin errors++; $display("FAIL sraiw_decode: op=%0d w=%b required 7/1", r_alu_op, r_alu_w); end
        // slli.uw x3 with shamt[5]=1
        run_op(mk(7'b0000101, 3'b001, 5'd3, 7'b0011011), 0, 0, 10);
        checks++; if ({r_alu_op, r_alu_w} !== 5'b1110_0)
            begin errors++; $display("FAIL slli_uw_decode: op=%0d w=%b required 14/0", r_alu_op, r_alu_w); end
        // sub x0: retires but never writes x0
        run_op(mk(7'b0100000, 3'b000, 5'd0, 7'b0110011), 0, 0, 10);
        checks++; if ({r_alu_op, r_rf_we, r_pc_we} !== 6'b0001_0_1)
            begin errors++; $display("FAIL sub_x0: op=%0d rf_we=%b pc_we=%b required 1/0/1", r_alu_op, r_rf_we, r_pc_we); end
    endtask

    task automatic test_illegal();
        logic [31:0] bad [4];
        bad[0] = I_BAD;
        bad[1] = mk(7'b0001000, 3'b001, 5'd1, 7'b0011011);
        bad[2] = mk(7'b0000000, 3'b111, 5'd1, 7'b0000011);
        bad[3] = mk(7'b0000000, 3'b100, 5'd0, 7'b0100011);
        for (int i = 0; i < 4; i++) begin
            do_reset();
            run_op(bad[i], 0, 0, 5);
            checks++; if (r_illegal_cyc !== 3) begin errors++; $display("FAIL illegal_%0d_cycle: got %0d required 3", i, r_illegal_cyc); end
            checks++; if (r_retire_cyc !== -1) begin errors++; $display("FAIL illegal_%0d_retire: got cycle %0d required none", i, r_retire_cyc); end
        end
        imem_valid = 1'b1;
        dmem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({illegal, imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, retire} !== 8'b1000_0000) begin
            errors++;
            $display("FAIL trap_sticky: illegal=%b imem_req=%b ir_we=%b dmem_req=%b retire=%b required 1/0/0/0/0",
                     illegal, imem_req, ir_we, dmem_req, retire);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL trap_clear: got %b required 0", illegal); end
        imem_valid = 1'b0;
        dmem_ready = 1'b0;
        do_reset();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL trap_restart: got %b required 1", imem_req); end
    endtask

    task automatic test_timeout();
        do_reset();
        run_op(I_LD, 0, -1, 12);
        checks++; if (r_illegal_cyc !== 8) begin errors++; $display("FAIL timeout_cycle: got %0d required 8", r_illegal_cyc); end
        checks++; if (r_req_cycles !== 4)  begin errors++; $display("FAIL timeout_req_cycles: got %0d required 4", r_req_cycles); end
        checks++; if ({dmem_req, r_retires[0]} !== 2'b00)
            begin errors++; $display("FAIL timeout_quiet: dmem_req=%b retires=%0d required 0/0", dmem_req, r_retires); end
        // ready in the last allowed MEM cycle beats the timeout
        do_reset();
        run_op(I_LD, 0, 3, 12);
        checks++; if (r_retire_cyc !== 8)  begin errors++; $display("FAIL ready_wins_retire: got %0d required 8", r_retire_cyc); end
        checks++; if (r_illegal_cyc !== -1) begin errors++; $display("FAIL ready_wins_illegal: got cycle %0d required none", r_illegal_cyc); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        run_op(I_LD, 0, -1, 5);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL midmem_req_before: got %b required 1", dmem_req); end
        dmem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, retire, pc_we} !== 3'b000) begin
            errors++;
            $display("FAIL midmem_reset: dmem_req=%b retire=%b pc_we=%b required 000", dmem_req, retire, pc_we);
        end
        @(posedge clk);
        #2;
        checks++; if (retire !== 1'b0) begin errors++; $display("FAIL midmem_no_retire: got %b required 0", retire); end
        dmem_ready = 1'b0;
        do_reset();
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midmem_restart: got %b required 1", imem_req); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu_add_uw();
        test_fetch_stall();
        test_load();
        test_store();
        test_decode_misc();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
Multi-cycle control FSM for the RV64I+Zba core. It sequences each instruction through fetch, decode, execute, memory and writeback.
- Consumes the field outputs of the instruction decoder (opcode, funct3, funct7, rd) taken from the latched instruction register.
- Drives the IR/PC enables, the ALU/immediate selects, the data-memory request and the register-file write enable.
- Classifies legal vs illegal encodings and halts on an illegal one.

Parameters:
DMEM_TIMEOUT, 0, cycles to wait for dmem_ready before trapping; 0 disables the timeout.
TMO_W, 8, width of the timeout counter; DMEM_TIMEOUT must be < 2**TMO_W.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction fetch request
imem_valid  in  1  instruction word valid this cycle
ir_we  out  1  latch the fetched word into the IR
opcode  in  7  decoded opcode
funct3  in  3  decoded funct3
funct7  in  7  decoded funct7 (instr[31:25])
rd  in  5  destination register index
alu_op  out  4  ALU operation code
alu_w  out  1  32-bit (W) op: sign-extend result[31:0]
alu_src_imm  out  1  ALU operand B from immediate
imm_sel  out  1  0 = I-type immediate, 1 = S-type immediate
dmem_req  out  1  data-memory request
dmem_we  out  1  data-memory write (store)
dmem_ready  in  1  data-memory transaction complete
rf_we  out  1  register-file write enable
wb_sel  out  1  0 = ALU result, 1 = load data
pc_we  out  1  PC <= PC+4
retire  out  1  one-cycle pulse per retired instruction
illegal  out  1  sticky trap flag (illegal encoding or dmem timeout)

Behaviour:
- **States:** FETCH, DECODE, EXEC, MEM, WB, TRAP. The state register is reset asynchronously to FETCH. All outputs are 0 while rst_n=0. After reset release, imem_req is asserted on the first clock.
- **FETCH:** imem_req=1. When imem_valid=1: ir_we=1 in the same cycle, next state DECODE. Otherwise stay in FETCH.
- **DECODE:** classify the instruction and register alu_op, alu_w, alu_src_imm, imm_sel and the class (ALU/LOAD/STORE). Legal goes to EXEC; illegal goes to TRAP.
- **Legal encodings:**
  - OP 0110011: funct7 0000000/0100000 (base ALU); funct7 0010000 with funct3 010/100/110 = sh1add/sh2add/sh3add.
  - OP-32 0111011: addw/subw/sllw/srlw/sraw; funct7 0000100 funct3 000 = add.uw; funct7 0010000 funct3 010/100/110 = shNadd.uw.
  - OP-IMM 0010011: all funct3. For shifts, funct7[6:1] must be 000000 or 010000.
  - OP-IMM-32 0011011: addiw/slliw/srliw/sraiw; funct3 001 with funct7[6:1]=000010 = slli.uw.
  - LOAD 0000011: funct3 != 111.
  - STORE 0100011: funct3 <= 011.
  - Everything else is illegal.
- **alu_op encoding:** 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 SH1ADD, 11 SH2ADD, 12 SH3ADD, 13 ADD_UW, 14 SLLI_UW.
  - LOAD and STORE use ADD with alu_src_imm=1; STORE additionally sets imm_sel=1.
  - alu_w=1 only for the base OP-32/OP-IMM-32 word ops, never for the .uw ops.
- **EXEC** (one cycle): ALU class goes to WB; LOAD/STORE go to MEM.
- **MEM:**
  - dmem_req=1, dmem_we=1 for STORE. Both are held stable until dmem_ready=1.
  - On dmem_ready: LOAD goes to WB; STORE asserts pc_we=1 and retire=1 in that cycle and goes to FETCH.
  - dmem_ready is ignored in every other state.
  - If DMEM_TIMEOUT>0: the counter starts at 0 on MEM entry and increments each cycle without ready. When it reaches DMEM_TIMEOUT, go to TRAP; ready arriving in that same cycle wins.
- **WB** (one cycle):
  - rf_we = (rd != 0); wb_sel=1 for LOAD.
  - pc_we=1, retire=1; next state FETCH.
- **TRAP:** illegal=1; all request/enable outputs 0. Stays in TRAP until rst_n=0.
- **Latency:** ALU op 4 cycles, load 5 cycles, store 4 cycles, each with zero-wait memories.
- **Reset mid-operation:** an outstanding dmem_req drops immediately and no retire is produced.

Optional Feature:
Macro CORE_CTRL_PERF_EN.
- **Defined:** adds outputs perf_cycles[63:0] and perf_instret[63:0], both reset to 0.
  - perf_cycles increments every clock outside TRAP.
  - perf_instret increments on each retire pulse.
  - Both wrap modulo 2**64.
- **Not defined:** the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. add.uw x5 (0x080302BB), imem_valid immediate -> retire in cycle 4; alu_op=13, alu_w=0, rf_we=1 in WB.
2. sh3add x1 (0x2030E0B3) with imem_valid delayed 3 cycles -> FETCH held with imem_req=1; alu_op=12; retire on cycle 7.
3. ld x7,8(x2) (0x00813383), dmem_ready delayed 2 cycles -> dmem_req held 3 cycles, dmem_we=0, wb_sel=1, retire on cycle 7.
4. sd (0x00713423), dmem_ready in first MEM cycle -> dmem_we=1, imm_sel=1, no rf_we, retire on cycle 4.
5. Illegal encodings 0x0000007F and slli.uw with funct7=0001000 -> TRAP after DECODE, illegal=1 sticky, imem_req=0; deasserting rst_n clears it and FETCH restarts.
6. DMEM_TIMEOUT=4, load with dmem_ready never asserted -> TRAP after 4 MEM cycles. Separately, rst_n pulsed during MEM -> dmem_req=0 immediately, no retire pulse.
